// File: rtl/tex_lane_serializer_if.sv
// rtl/tex_lane_serializer_if.sv - request/sample handshake bundle for tex_lane_serializer
`ifndef TEX_LOD_BITS
`define TEX_LOD_BITS 4
`endif
`ifndef TEX_STAGE_BITS
`define TEX_STAGE_BITS 3
`endif

interface tex_lane_serializer_if #(
    parameter int NUM_LANES = 4,
    parameter int TAG_WIDTH = 8
);
    localparam int LANE_BITS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic                                      req_valid;
    logic                                      req_ready;
    logic [NUM_LANES-1:0]                      req_mask;
    logic [1:0][NUM_LANES-1:0][31:0]           req_coords;
    logic [NUM_LANES-1:0][`TEX_LOD_BITS-1:0]   req_lod;
    logic [`TEX_STAGE_BITS-1:0]                req_stage;
    logic [TAG_WIDTH-1:0]                      req_tag;

    logic                                      out_valid;
    logic                                      out_ready;
    logic [31:0]                               out_u;
    logic [31:0]                               out_v;
    logic [`TEX_LOD_BITS-1:0]                  out_lod;
    logic [`TEX_STAGE_BITS-1:0]                out_stage;
    logic [TAG_WIDTH-1:0]                      out_tag;
    logic [LANE_BITS-1:0]                      out_lane;
    logic                                      out_last;

    modport slave (
        input  req_valid, req_mask, req_coords, req_lod, req_stage, req_tag, out_ready,
        output req_ready, out_valid, out_u, out_v, out_lod, out_stage, out_tag, out_lane, out_last
    );

    modport master (
        output req_valid, req_mask, req_coords, req_lod, req_stage, req_tag, out_ready,
        input  req_ready, out_valid, out_u, out_v, out_lod, out_stage, out_tag, out_lane, out_last
    );
endinterface

// File: rtl/tex_lane_serializer.sv
// rtl/tex_lane_serializer.sv - splits a multi-lane texture request into single-lane samples
// Define TEX_SERIAL_OVERLAP_EN to accept the next request in the final-lane handshake cycle.
`ifndef TEX_LOD_BITS
`define TEX_LOD_BITS 4
`endif
`ifndef TEX_STAGE_BITS
`define TEX_STAGE_BITS 3
`endif

module tex_lane_serializer #(
    parameter int NUM_LANES = 4,
    parameter int TAG_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    tex_lane_serializer_if.slave   bus
);
    localparam int LANE_BITS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                                    r_state, w_state_nxt;
    logic [NUM_LANES-1:0]                      r_mask, w_mask_nxt, w_lane_oh;
    logic [1:0][NUM_LANES-1:0][31:0]           r_coords;
    logic [NUM_LANES-1:0][`TEX_LOD_BITS-1:0]   r_lod;
    logic [`TEX_STAGE_BITS-1:0]                r_stage;
    logic [TAG_WIDTH-1:0]                      r_tag;
    logic [LANE_BITS-1:0]                      w_lane;
    logic                                      w_busy, w_single, w_accept, w_load;

    // Isolate the lowest pending lane; the request is on its last lane when nothing else remains.
    assign w_lane_oh = r_mask & (~r_mask + NUM_LANES'(1));
    assign w_single  = (r_mask & ~w_lane_oh) == '0;
    assign w_busy    = (r_state == BUSY);

    always_comb begin
        w_lane = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (r_mask[i]) w_lane = LANE_BITS'(i);
        end
    end

`ifdef TEX_SERIAL_OVERLAP_EN
    assign bus.req_ready = !w_busy || (w_single && bus.out_ready);
`else
    assign bus.req_ready = !w_busy;
`endif
    assign w_accept = bus.req_valid && bus.req_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && (bus.req_mask != '0)) begin
                    w_load      = 1'b1;
                    w_mask_nxt  = bus.req_mask;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus.out_ready) begin
                    w_mask_nxt = r_mask & ~w_lane_oh;
                    if (w_single) begin
                        w_state_nxt = IDLE;
                        if (w_accept && (bus.req_mask != '0)) begin
                            w_load      = 1'b1;
                            w_mask_nxt  = bus.req_mask;
                            w_state_nxt = BUSY;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_mask   <= '0;
            r_coords <= '0;
            r_lod    <= '0;
            r_stage  <= '0;
            r_tag    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            if (w_load) begin
                r_coords <= bus.req_coords;
                r_lod    <= bus.req_lod;
                r_stage  <= bus.req_stage;
                r_tag    <= bus.req_tag;
            end
        end
    end

    assign bus.out_valid = w_busy;
    assign bus.out_last  = w_busy && w_single;
    assign bus.out_lane  = w_lane;
    assign bus.out_u     = r_coords[0][w_lane];
    assign bus.out_v     = r_coords[1][w_lane];
    assign bus.out_lod   = r_lod[w_lane];
    assign bus.out_stage = r_stage;
    assign bus.out_tag   = r_tag;
endmodule

// File: tb/tb_tex_lane_serializer.sv
// tb/tb_tex_lane_serializer.sv - scoreboard bench for tex_lane_serializer
`ifndef TEX_LOD_BITS
`define TEX_LOD_BITS 4
`endif
`ifndef TEX_STAGE_BITS
`define TEX_STAGE_BITS 3
`endif

module tb_tex_lane_serializer;
    localparam int NL   = 4;
    localparam int TW   = 8;
    localparam int LODW = `TEX_LOD_BITS;
    localparam int STW  = `TEX_STAGE_BITS;
`ifdef TEX_SERIAL_OVERLAP_EN
    localparam int GAP  = 1;
`else
    localparam int GAP  = 2;
`endif

    typedef struct {
        logic [1:0]      lane;
        logic [31:0]     u;
        logic [31:0]     v;
        logic [LODW-1:0] lod;
        logic [STW-1:0]  stage;
        logic [TW-1:0]   tag;
        logic            last;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    tex_lane_serializer_if #(.NUM_LANES(NL), .TAG_WIDTH(TW)) bus ();
    tex_lane_serializer #(.NUM_LANES(NL), .TAG_WIDTH(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    int   hs_q[$];
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] coord_u(input logic [7:0] tag, input logic [1:0] lane);
        return {8'hA0, tag, 14'h0, lane};
    endfunction

    function automatic logic [31:0] coord_v(input logic [7:0] tag, input logic [1:0] lane);
        return {8'hB0, tag, 14'h0, lane};
    endfunction

    function automatic logic [LODW-1:0] lane_lod(input logic [7:0] tag, input logic [1:0] lane);
        return LODW'(tag + 8'(lane) + 8'd1);
    endfunction

    task automatic send(input logic [NL-1:0] mask, input logic [TW-1:0] tag, input logic [STW-1:0] stage);
        exp_t e;
        int   hi;
        bit   acc;
        hi = -1;
        for (int i = 0; i < NL; i++) begin
            bus.req_coords[0][i] = coord_u(tag, 2'(i));
            bus.req_coords[1][i] = coord_v(tag, 2'(i));
            bus.req_lod[i]       = lane_lod(tag, 2'(i));
            if (mask[i]) hi = i;
        end
        bus.req_mask  = mask;
        bus.req_tag   = tag;
        bus.req_stage = stage;
        bus.req_valid = 1'b1;
        for (int i = 0; i < NL; i++) begin
            if (mask[i]) begin
                e.lane  = 2'(i);
                e.u     = coord_u(tag, 2'(i));
                e.v     = coord_v(tag, 2'(i));
                e.lod   = lane_lod(tag, 2'(i));
                e.stage = stage;
                e.tag   = tag;
                e.last  = (i == hi);
                exp_q.push_back(e);
            end
        end
        acc = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            acc = bus.req_ready;
            if (acc) acc_cyc = cyc;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) check("send_timeout", 64'(0), 64'(1));
        bus.req_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset && bus.out_valid && bus.out_ready) begin
            hs_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("out_lane",  64'(bus.out_lane),  64'(e.lane));
                check("out_u",     64'(bus.out_u),     64'(e.u));
                check("out_v",     64'(bus.out_v),     64'(e.v));
                check("out_lod",   64'(bus.out_lod),   64'(e.lod));
                check("out_stage", 64'(bus.out_stage), 64'(e.stage));
                check("out_tag",   64'(bus.out_tag),   64'(e.tag));
                check("out_last",  64'(bus.out_last),  64'(e.last));
            end
        end
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_mask   = '0;
        bus.req_coords = '0;
        bus.req_lod    = '0;
        bus.req_stage  = '0;
        bus.req_tag    = '0;
        bus.out_ready  = 1'b1;
        reset          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'(1));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_last",  64'(bus.out_last),  64'(0));
        check("rst_out_lane",  64'(bus.out_lane),  64'(0));
        check("rst_out_u",     64'(bus.out_u),     64'(0));
        check("rst_out_tag",   64'(bus.out_tag),   64'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;

        // mask 1011, lanes 0,1,3 back to back
        hs_q.delete();
        send(4'b1011, 8'h5A, 3'd2);
        repeat (6) @(posedge clk);
        #1;
        check("m1011_count", 64'(hs_q.size()), 64'(3));
        if (hs_q.size() == 3) begin
            check("m1011_first_lat", 64'(hs_q[0] - acc_cyc), 64'(1));
            check("m1011_gap01",     64'(hs_q[1] - hs_q[0]), 64'(1));
            check("m1011_gap13",     64'(hs_q[2] - hs_q[1]), 64'(1));
        end

        // empty mask is dropped
        hs_q.delete();
        send(4'b0000, 8'h99, 3'd1);
        @(negedge clk);
        check("m0000_req_ready", 64'(bus.req_ready), 64'(1));
        check("m0000_out_valid", 64'(bus.out_valid), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        check("m0000_count", 64'(hs_q.size()), 64'(0));

        // stall on lane 1 for three cycles
        hs_q.delete();
        bus.out_ready = 1'b0;
        send(4'b0110, 8'h3C, 3'd5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_valid", 64'(bus.out_valid), 64'(1));
            check("stall_lane",  64'(bus.out_lane),  64'(1));
            check("stall_u",     64'(bus.out_u),     64'(coord_u(8'h3C, 2'd1)));
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("stall_count", 64'(hs_q.size()), 64'(2));

        // back-to-back single-lane requests
        hs_q.delete();
        send(4'b0001, 8'h11, 3'd1);
        send(4'b1000, 8'h22, 3'd6);
        repeat (5) @(posedge clk);
        #1;
        check("b2b_count", 64'(hs_q.size()), 64'(2));
        if (hs_q.size() == 2) check("b2b_gap", 64'(hs_q[1] - hs_q[0]), 64'(GAP));

        // reset while busy after two lanes
        hs_q.delete();
        send(4'b1111, 8'h77, 3'd7);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("rb_out_valid", 64'(bus.out_valid), 64'(0));
        check("rb_req_ready", 64'(bus.req_ready), 64'(1));
        check("rb_out_lane",  64'(bus.out_lane),  64'(0));
        check("rb_out_u",     64'(bus.out_u),     64'(0));
        exp_q.delete();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rb_count",       64'(hs_q.size()),  64'(2));
        check("rb_still_idle",  64'(bus.out_valid), 64'(0));

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tex_lane_serializer.md
TEX_LANE_SERIALIZER -- requirements
Module: tex_lane_serializer

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: lanes per incoming texture request.
REQ-002 SHALL have parameter TAG_WIDTH, default 8: request tag width, passed through unchanged.
REQ-003 SHALL derive LANE_BITS = max(1, clog2(NUM_LANES)); LOD and stage widths SHALL be `TEX_LOD_BITS and `TEX_STAGE_BITS.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-007 req_valid  input  1  incoming texture request valid.
REQ-008 req_mask  input  NUM_LANES  active-lane mask.
REQ-009 req_coords  input  2 x NUM_LANES x 32  per-lane u (index 0) and v (index 1).
REQ-010 req_lod  input  NUM_LANES x `TEX_LOD_BITS  per-lane LOD.
REQ-011 req_stage  input  `TEX_STAGE_BITS  texture stage.
REQ-012 req_tag  input  TAG_WIDTH  request tag.
REQ-013 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-014 out_valid  output  1  single-lane sample valid.
REQ-015 out_u, out_v  output  32 each  coordinates of current lane.
REQ-016 out_lod  output  `TEX_LOD_BITS  LOD of current lane.
REQ-017 out_stage, out_tag  output  `TEX_STAGE_BITS, TAG_WIDTH  captured request stage and tag.
REQ-018 out_lane  output  LANE_BITS  index of current lane.
REQ-019 out_last  output  1  current lane is the final active lane of its request.
REQ-020 out_ready  input  1  downstream accepts when out_valid && out_ready.

Function
REQ-021 SHALL implement two states: IDLE and BUSY.
REQ-022 In IDLE, req_ready SHALL be 1 and out_valid SHALL be 0.
REQ-023 IDLE, accept with req_mask != 0: SHALL capture all request fields, set pending mask = req_mask, go BUSY.
REQ-024 IDLE, accept with req_mask == 0: SHALL drop the request, emit nothing, stay IDLE.
REQ-025 In BUSY, out_valid SHALL be 1; out_lane SHALL be the lowest set bit index of the pending mask; out_u/out_v/out_lod SHALL be that lane's captured values.
REQ-026 out_last SHALL be 1 iff the pending mask has exactly one bit set.
REQ-027 On output handshake, the served bit SHALL be cleared from the pending mask; with out_last = 1, state SHALL return to IDLE (unless REQ-035 applies).
REQ-028 All out_* signals SHALL hold stable while out_valid && !out_ready.
REQ-029 Latency: first lane valid the cycle after acceptance; one lane per cycle while out_ready = 1; N active lanes take exactly N output handshakes.
REQ-030 Lanes SHALL be emitted in ascending index order; inactive lanes SHALL never be emitted.
REQ-031 req_ready SHALL be 0 in BUSY except as in REQ-035; requests presented while not ready SHALL NOT be captured.

Reset
REQ-032 While reset = 0 at a clock edge: state = IDLE, pending mask = 0, all captured registers = 0.
REQ-033 Outputs after reset: req_ready = 1, out_valid = 0, out_last = 0, out_lane = 0, all data outputs 0.
REQ-034 Reset during BUSY SHALL discard remaining lanes with no further output.

Configuration
REQ-035 Macro TEX_SERIAL_OVERLAP_EN defined: req_ready = IDLE || (out_valid && out_last && out_ready); an accept in that cycle SHALL load the new request (zero-bubble), or go IDLE if its mask is 0.
REQ-036 Macro TEX_SERIAL_OVERLAP_EN undefined: req_ready = 1 only in IDLE; one bubble cycle between requests.

Verification
REQ-037 NUM_LANES=4, mask 4'b1011, tag 0x5A, out_ready=1 -> lanes 0,1,3 on consecutive cycles, out_last only on lane 3, out_tag=0x5A each cycle.
REQ-038 mask 4'b0000 accepted -> no out_valid; req_ready stays 1 the next cycle.
REQ-039 mask 4'b0110, out_ready=0 for 3 cycles -> out_lane=1 and out_u unchanged throughout; lane 2 follows after out_ready rises.
REQ-040 Back-to-back requests mask 4'b0001 then 4'b1000 -> lane 3 appears the cycle after lane 0 with overlap macro; one idle cycle between them without it.
REQ-041 reset=0 while BUSY with mask 4'b1111 after two lanes served -> next cycle out_valid=0, req_ready=1; lanes 2 and 3 never emitted.
